ysyx_25030093_mem_arb: RTL and testbench

- Two-master, one-slave arbiter sharing the core's single memory port between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Uses the same valid/ready handshake style as the decode/execute stages.
- Allows one outstanding transaction at a time; request fields are registered, and responses are routed back to the granted owner.
- Sits between the IFU/LSU and the memory/SRAM bridge.

---
 rtl/ysyx_25030093_bus_pkg.sv | 18 +
 rtl/ysyx_25030093_rr_pick2.sv | 15 +
 rtl/ysyx_25030093_mem_arb.sv | 235 +++++++++++++++++++++++
 tb/tb_ysyx_25030093_mem_arb.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25030093_bus_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter.
//   ST_*      : arbiter state encoding (ST_ERR is only reachable when ARB_TIMEOUT_EN is defined)
//   OWN_*     : transaction owner encoding
//   ADDR_W / DATA_W : default bus widths
package ysyx_25030093_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/ysyx_25030093_rr_pick2.sv
// Combinational two-way round-robin picker.
//   req[0] : IFU request, req[1] : LSU request
//   last   : owner of the previous completed transaction (0 = IFU, 1 = LSU)
//   gnt    : one-hot grant, zero when nothing is requested
module ysyx_25030093_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On a tie the master that did not go last wins.
    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/ysyx_25030093_mem_arb.sv
// Two-master / one-slave memory arbiter between the IFU (read-only) and the
// LSU (read/write), one outstanding transaction at a time.
//
// Optional feature: define ARB_TIMEOUT_EN to add a response timeout. After
// TIMEOUT silent response cycles the owner receives an error response and the
// late slave response, when it arrives, is drained before any new grant.
//
// Ports:
//   clock, reset (async, active-low)
//   ifu_req_* / ifu_resp_*  : IFU request/response handshake
//   lsu_req_* / lsu_resp_*  : LSU request/response handshake
//   mem_req_* / mem_resp_*  : slave side towards the SRAM bridge
//
// state | meaning
// IDLE  | waiting for a request, grant combinational
// REQ   | latched request presented to the slave
// RESP  | waiting for the slave response, routed to owner
// ERR   | timeout error response to owner (ARB_TIMEOUT_EN only)
module ysyx_25030093_mem_arb #(
    parameter int ADDR_W  = ysyx_25030093_bus_pkg::ADDR_W,
    parameter int DATA_W  = ysyx_25030093_bus_pkg::DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp_err
);

    import ysyx_25030093_bus_pkg::*;

    localparam int STRB_W = DATA_W / 8;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [1:0]        gnt;
    logic              grant_open;
    logic              owner_rready;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drain_q, drain_d;
`endif

    ysyx_25030093_rr_pick2 u_pick (
        .req  ({lsu_req_valid, ifu_req_valid}),
        .last (last_q),
        .gnt  (gnt)
    );

    // Readies are gated with reset so every ready reads 0 while reset is held,
    // even if a master is already requesting.
`ifdef ARB_TIMEOUT_EN
    assign grant_open = (state_q == ST_IDLE) && reset && !drain_q;
`else
    assign grant_open = (state_q == ST_IDLE) && reset;
`endif
    assign ifu_req_ready = grant_open & gnt[0];
    assign lsu_req_ready = grant_open & gnt[1];

    assign owner_rready = (owner_q == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_d         = last_q;
        addr_d         = addr_q;
        wen_d          = wen_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d          = cnt_q;
        drain_d        = drain_q;
`endif
        mem_req_valid  = 1'b0;
        mem_addr       = '0;
        mem_wen        = 1'b0;
        mem_wdata      = '0;
        mem_wstrb      = '0;
        mem_resp_ready = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        ifu_resp_err   = 1'b0;
        lsu_resp_valid = 1'b0;
        lsu_rdata      = '0;
        lsu_resp_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
`ifdef ARB_TIMEOUT_EN
                // Swallow the late response of a timed-out transaction.
                if (drain_q) begin
                    mem_resp_ready = 1'b1;
                    if (mem_resp_valid) drain_d = 1'b0;
                end
`endif
                if (ifu_req_valid && ifu_req_ready) begin
                    owner_d = OWN_IFU;
                    addr_d  = ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wstrb_d = '0;
                    state_d = ST_REQ;
                end else if (lsu_req_valid && lsu_req_ready) begin
                    owner_d = OWN_LSU;
                    addr_d  = lsu_addr;
                    wen_d   = lsu_wen;
                    wdata_d = lsu_wdata;
                    wstrb_d = lsu_wstrb;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = addr_q;
                mem_wen       = wen_q;
                mem_wdata     = wdata_q;
                mem_wstrb     = wstrb_q;
                if (mem_req_ready) begin
                    state_d = ST_RESP;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_RESP: begin
                mem_resp_ready = owner_rready;
                if (owner_q == OWN_LSU) begin
                    lsu_resp_valid = mem_resp_valid;
                    lsu_rdata      = mem_rdata;
                    lsu_resp_err   = mem_resp_err;
                end else begin
                    ifu_resp_valid = mem_resp_valid;
                    ifu_rdata      = mem_rdata;
                    ifu_resp_err   = mem_resp_err;
                end
                if (mem_resp_valid && owner_rready) begin
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (!mem_resp_valid) begin
                    // cnt_q counts completed silent cycles; the TIMEOUT-th one ends the wait.
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d = ST_ERR;
                        drain_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
            end
            default: begin
`ifdef ARB_TIMEOUT_EN
                if (owner_q == OWN_LSU) begin
                    lsu_resp_valid = 1'b1;
                    lsu_resp_err   = 1'b1;
                end else begin
                    ifu_resp_valid = 1'b1;
                    ifu_resp_err   = 1'b1;
                end
                if (owner_rready) begin
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_IFU;
            last_q  <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            drain_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
`endif
        end
    end

endmodule

// File: tb/tb_ysyx_25030093_mem_arb.sv
module tb_ysyx_25030093_mem_arb;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wstrb;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready, mem_resp_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ysyx_25030093_mem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
    );

    // One record per clock cycle: inputs applied after the falling edge, outputs
    // compared 1 time unit later, before the next rising edge.
    typedef struct packed {
        logic [31:0] rst, iv, ia, irr, lv, la, lw, ld, ls, lrr, mrq, mrv, mrd, mre;
    } in_t;
    typedef struct packed {
        logic [31:0] ir, lr, mv, ma, mw, md, ms, mrr, iv, id, ie, lv, ld, le;
    } out_t;
    typedef struct packed {
        in_t  i;
        out_t e;
    } vec_t;

    vec_t vq[$];

    task automatic add(input in_t i, input out_t e);
        vec_t t;
        t.i = i;
        t.e = e;
        vq.push_back(t);
    endtask

    task automatic apply(input in_t i);
        reset          = i.rst[0];
        ifu_req_valid  = i.iv[0];
        ifu_addr       = i.ia;
        ifu_resp_ready = i.irr[0];
        lsu_req_valid  = i.lv[0];
        lsu_addr       = i.la;
        lsu_wen        = i.lw[0];
        lsu_wdata      = i.ld;
        lsu_wstrb      = i.ls[3:0];
        lsu_resp_ready = i.lrr[0];
        mem_req_ready  = i.mrq[0];
        mem_resp_valid = i.mrv[0];
        mem_rdata      = i.mrd;
        mem_resp_err   = i.mre[0];
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    localparam logic [31:0] IA = 32'h0000_1000;
    localparam logic [31:0] LA = 32'h0000_2000;

    initial begin
        out_t got;
        in_t  idle_in;

        apply('{0,0,0,0,0,0,0,0,0,0,0,0,0,0});

        //    rst iv ia            irr lv la            lw ld            ls lrr mrq mrv mrd           mre     ir lr mv ma            mw md            ms mrr iv id            ie lv ld       le
        // reset held with both masters requesting: everything quiet
        add('{0, 1, IA,           0,  1, LA,           0, 0,            0, 0,  0,  0,  0,            0}, '{0, 0, 0, 0,            0, 0,            0, 0,  0, 0,            0, 0, 0,       0});
        add('{0, 1, IA,           0,  1, LA,           0, 0,            0, 0,  0,  0,  0,            0}, '{0, 0, 0, 0,            0, 0,            0, 0,  0, 0,            0, 0, 0,       0});
        // first tie after reset goes to LSU, then alternates IFU, LSU
        add('{1, 1, IA,           0,  1, LA,           0, 0,            0, 0,  0,  0,  0,            0}, '{0, 1, 0, 0,            0, 0,            0, 0,  0, 0,            0, 0, 0,       0});
        add('{1, 1, IA,           0,  1, LA,           0, 0,            0, 0,  1,  0,  0,            0}, '{0, 0, 1, LA,           0, 0,            0, 0,  0, 0,            0, 0, 0,       0});
        add('{1, 1, IA,           1,  1, LA,           0, 0,            0, 1,  0,  1,  32'h11,       0}, '{0, 0, 0, 0,            0, 0,            0, 1,  0, 0,            0, 1, 32'h11,  0});
        add('{1, 1, IA,           0,  1, LA,           0, 0,            0, 0,  0,  0,  0,            0}, '{1, 0, 0, 0,            0, 0,            0, 0,  0, 0,            0, 0, 0,       0});
        add('{1, 1, IA,           0,  1, LA,           0, 0,            0, 0,  1,  0,  0,            0}, '{0, 0, 1, IA,           0, 0,            0, 0,  0, 0,            0, 0, 0,       0});
        add('{1, 1, IA,           1,  1, LA,           0, 0,            0, 1,  0,  1,  32'h22,       0}, '{0, 0, 0, 0,            0, 0,            0, 1,  1, 32'h22,       0, 0, 0,       0});
        add('{1, 1, IA,           0,  1, LA,           0, 0,            0, 0,  0,  0,  0,            0}, '{0, 1, 0, 0,            0, 0,            0, 0,  0, 0,            0, 0, 0,       0});
        add('{1, 1, IA,           0,  1, LA,           0, 0,            0, 0,  1,  0,  0,            0}, '{0, 0, 1, LA,           0, 0,            0, 0,  0, 0,            0, 0, 0,       0});
        add('{1, 0, 0,            0,  0, 0,            0, 0,            0, 1,  0,  1,  32'h33,       0}, '{0, 0, 0, 0,            0, 0,            0, 1,  0, 0,            0, 1, 32'h33,  0});
        // IFU fetch alone
        add('{1, 1, 32'h8000_0000,0,  0, 0,            0, 0,            0, 0,  0,  0,  0,            0}, '{1, 0, 0, 0,            0, 0,            0, 0,  0, 0,            0, 0, 0,       0});
        add('{1, 0, 0,            0,  0, 0,            0, 0,            0, 0,  1,  0,  0,            0}, '{0, 0, 1, 32'h8000_0000,0, 0,            0, 0,  0, 0,            0, 0, 0,       0});
        add('{1, 0, 0,            1,  0, 0,            0, 0,            0, 0,  0,  1,  32'h0000_0413,0}, '{0, 0, 0, 0,            0, 0,            0, 1,  1, 32'h0000_0413,0, 0, 0,       0});
        // LSU byte store
        add('{1, 0, 0,            0,  1, 32'h8000_1000,1, 32'hDEADBEEF, 1, 0,  0,  0,  0,            0}, '{0, 1, 0, 0,            0, 0,            0, 0,  0, 0,            0, 0, 0,       0});
        add('{1, 0, 0,            0,  0, 0,            0, 0,            0, 0,  1,  0,  0,            0}, '{0, 0, 1, 32'h8000_1000,1, 32'hDEADBEEF, 1, 0,  0, 0,            0, 0, 0,       0});
        add('{1, 0, 0,            0,  0, 0,            0, 0,            0, 1,  0,  1,  0,            0}, '{0, 0, 0, 0,            0, 0,            0, 1,  0, 0,            0, 1, 0,       0});
        add('{1, 0, 0,            0,  0, 0,            0, 0,            0, 1,  0,  0,  0,            0}, '{0, 0, 0, 0,            0, 0,            0, 0,  0, 0,            0, 0, 0,       0});
        // LSU read; slave stalls the request 5 cycles, LSU stalls the response 3 cycles
        add('{1, 0, 0,            0,  1, 32'hC0,       0, 0,            0, 0,  0,  0,  0,            0}, '{0, 1, 0, 0,            0, 0,            0, 0,  0, 0,            0, 0, 0,       0});
        for (int k = 0; k < 5; k++)
        add('{1, 1, IA,           0,  0, 0,            0, 0,            0, 0,  0,  0,  0,            0}, '{0, 0, 1, 32'hC0,       0, 0,            0, 0,  0, 0,            0, 0, 0,       0});
        add('{1, 1, IA,           0,  0, 0,            0, 0,            0, 0,  1,  0,  0,            0}, '{0, 0, 1, 32'hC0,       0, 0,            0, 0,  0, 0,            0, 0, 0,       0});
        for (int k = 0; k < 3; k++)
        add('{1, 1, IA,           0,  0, 0,            0, 0,            0, 0,  0,  1,  32'h44,       1}, '{0, 0, 0, 0,            0, 0,            0, 0,  0, 0,            0, 1, 32'h44,  1});
        add('{1, 1, IA,           0,  0, 0,            0, 0,            0, 1,  0,  1,  32'h44,       1}, '{0, 0, 0, 0,            0, 0,            0, 1,  0, 0,            0, 1, 32'h44,  1});
        // IFU now granted, then reset hits while its response is pending
        add('{1, 1, IA,           0,  0, 0,            0, 0,            0, 0,  0,  0,  0,            0}, '{1, 0, 0, 0,            0, 0,            0, 0,  0, 0,            0, 0, 0,       0});
        add('{1, 0, 0,            0,  0, 0,            0, 0,            0, 0,  1,  0,  0,            0}, '{0, 0, 1, IA,           0, 0,            0, 0,  0, 0,            0, 0, 0,       0});
        add('{1, 0, 0,            1,  0, 0,            0, 0,            0, 0,  0,  0,  0,            0}, '{0, 0, 0, 0,            0, 0,            0, 1,  0, 0,            0, 0, 0,       0});
        add('{0, 1, IA,           1,  1, LA,           0, 0,            0, 1,  1,  1,  32'h55,       1}, '{0, 0, 0, 0,            0, 0,            0, 0,  0, 0,            0, 0, 0,       0});
        // fresh IFU transaction after release
        add('{1, 1, 32'h8000_0000,1,  0, 0,            0, 0,            0, 0,  0,  0,  0,            0}, '{1, 0, 0, 0,            0, 0,            0, 0,  0, 0,            0, 0, 0,       0});
        add('{1, 0, 0,            1,  0, 0,            0, 0,            0, 0,  1,  0,  0,            0}, '{0, 0, 1, 32'h8000_0000,0, 0,            0, 0,  0, 0,            0, 0, 0,       0});
        add('{1, 0, 0,            1,  0, 0,            0, 0,            0, 0,  0,  1,  32'h66,       0}, '{0, 0, 0, 0,            0, 0,            0, 1,  1, 32'h66,       0, 0, 0,       0});
        add('{1, 0, 0,            0,  0, 0,            0, 0,            0, 0,  0,  0,  0,            0}, '{0, 0, 0, 0,            0, 0,            0, 0,  0, 0,            0, 0, 0,       0});

        for (int n = 0; n < vq.size(); n++) begin
            @(negedge clock);
            apply(vq[n].i);
            #1;
            got = '{32'(ifu_req_ready), 32'(lsu_req_ready), 32'(mem_req_valid), mem_addr,
                    32'(mem_wen), mem_wdata, 32'(mem_wstrb), 32'(mem_resp_ready),
                    32'(ifu_resp_valid), ifu_rdata, 32'(ifu_resp_err),
                    32'(lsu_resp_valid), lsu_rdata, 32'(lsu_resp_err)};
            checks++;
            if (got !== vq[n].e) begin
                failures++;
                $display("FAIL vec%0d got=%h expected=%h", n, got, vq[n].e);
            end
        end

`ifdef ARB_TIMEOUT_EN
        idle_in = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        @(negedge clock);
        apply(idle_in);
        ifu_req_valid = 1'b1;
        ifu_addr      = IA;
        #1 chk("to_grant", 32'(ifu_req_ready), 1);
        @(negedge clock);
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1 chk("to_req", 32'(mem_req_valid), 1);
        mem_req_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            #1 chk("to_wait", 32'(ifu_resp_valid), 0);
        end
        @(negedge clock);
        #1;
        chk("to_err_valid", 32'(ifu_resp_valid), 1);
        chk("to_err_flag", 32'(ifu_resp_err), 1);
        chk("to_err_rdata", ifu_rdata, 0);
        @(negedge clock);
        ifu_req_valid  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h77;
        #1;
        chk("to_drain_nogrant", 32'(ifu_req_ready), 0);
        chk("to_drain_ready", 32'(mem_resp_ready), 1);
        chk("to_drain_hidden", 32'(ifu_resp_valid), 0);
        @(negedge clock);
        mem_resp_valid = 1'b0;
        #1 chk("to_regrant", 32'(ifu_req_ready), 1);
        @(negedge clock);
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1 chk("to_req2_addr", mem_addr, IA);
        @(negedge clock);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h88;
        #1 chk("to_resp2_data", ifu_rdata, 32'h88);
        @(negedge clock);
        apply(idle_in);
`else
        idle_in = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        @(negedge clock);
        apply(idle_in);
        // default build: a silent slave keeps the owner waiting with no error
        ifu_req_valid = 1'b1;
        ifu_addr      = IA;
        #1 chk("wait_grant", 32'(ifu_req_ready), 1);
        @(negedge clock);
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1 chk("wait_req", 32'(mem_req_valid), 1);
        mem_req_ready  = 1'b0;
        ifu_resp_ready = 1'b1;
        lsu_req_valid  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            #1;
            chk("wait_no_resp", 32'(ifu_resp_valid | ifu_resp_err), 0);
            chk("wait_no_grant", 32'(lsu_req_ready), 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
